// File: rtl/add_resp_pkg.sv
// add_resp_pkg: default operand width, result buffer depth and occupancy state encoding
package add_resp_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
endpackage

// File: rtl/add_resp_fifo.sv
// add_resp_fifo: show-ahead result buffer; wr/din push, rd pops head dout (0 when empty), count = entries held
module add_resp_fifo #(
  parameter int W = 5,
  parameter int D = 4,
  localparam int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [W-1:0]  din,
  input  logic          rd,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count
);
  logic [W-1:0]  mem [D];
  logic [AW-1:0] wptr, rptr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + {{(AW-1){1'b0}}, wr};
      rptr  <= rptr + {{(AW-1){1'b0}}, rd};
      count <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
    end
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= din;
  assign dout = (count != '0) ? mem[rptr] : '0;
endmodule

// File: rtl/add_resp.sv
// add_resp: a+b with valid/ready in, one-entry stage then result fifo out; state = occupancy class, done_cnt = deliveries mod 256
module add_resp
  import add_resp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   y,
  output logic [1:0]       state,
  output logic [7:0]       done_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] OCC_MAX = (AW+1)'(DEPTH);
  logic           up, sv, acc, del;
  logic [WIDTH:0] sd;
  logic [AW:0]    cnt, occ;
  state_t         st;
  assign occ       = cnt + {{AW{1'b0}}, sv};
  assign in_ready  = up && (occ < OCC_MAX);
  assign out_valid = cnt != '0;
  assign acc       = in_valid && in_ready;
  assign del       = out_valid && out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      up       <= 1'b0;
      sv       <= 1'b0;
      sd       <= '0;
      done_cnt <= '0;
    end else begin
      up       <= 1'b1;
      sv       <= acc;
      if (acc) sd <= {1'b0, a} + {1'b0, b};
      done_cnt <= done_cnt + {7'd0, del};
    end
  add_resp_fifo #(.W(WIDTH + 1), .D(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .wr(sv), .din(sd), .rd(del), .dout(y), .count(cnt)
  );
  always_comb st = (occ == OCC_MAX) ? FULL : (occ == '0) ? IDLE : BUSY;
  assign state = st;
endmodule

// File: tb/tb_add_resp.sv
// tb_add_resp: queue-model checker plus directed vectors for add_resp
module tb_add_resp;
  localparam int W = 4;
  localparam int D = 4;
  logic clk = 0, rst = 0, in_valid = 0, out_ready = 0;
  logic [W-1:0] a = 0, b = 0;
  logic in_ready, out_valid;
  logic [W:0] y;
  logic [1:0] state;
  logic [7:0] done_cnt;
  int nchk = 0, nerr = 0;
  int q[$], got[$];
  bit pend, up;
  int pv, mdone, acc_cnt;

  add_resp #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .state(state), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // results become visible one edge after acceptance; buffer holds at most D including the in-flight one
  always @(posedge clk or posedge rst) begin : model
    bit ma, md;
    if (rst) begin
      q.delete();
      pend = 0;
      up = 0;
      mdone = 0;
    end else begin
      ma = in_valid && up && (q.size() + int'(pend) < D);
      md = q.size() > 0 && out_ready;
      if (md) begin
        got.push_back(int'(y));
        void'(q.pop_front());
        mdone = (mdone + 1) % 256;
      end
      if (pend) q.push_back(pv);
      pend = ma;
      pv = int'(a) + int'(b);
      up = 1;
      if (ma) acc_cnt++;
    end
  end

  always @(negedge clk) begin : cmp
    int occ;
    occ = q.size() + int'(pend);
    chk("in_ready", int'(in_ready), int'(up && occ < D));
    chk("out_valid", int'(out_valid), int'(q.size() > 0));
    chk("state", int'(state), occ == D ? 2 : occ == 0 ? 0 : 1);
    chk("done_cnt", int'(done_cnt), mdone);
    if (q.size() > 0) chk("y", int'(y), q[0]);
    else if (rst) chk("y_rst", int'(y), 0);
  end

  initial begin
    #1 rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_state", int'(state), 0);
    #1 rst = 0;
    @(negedge clk);
    chk("ready_after_rst", int'(in_ready), 1);
    // single 5+5
    #1 a = 5; b = 5; in_valid = 1; out_ready = 1;
    @(negedge clk);
    chk("t31_ov_edge_k", int'(out_valid), 0);
    #1 in_valid = 0;
    @(negedge clk);
    chk("t31_ov", int'(out_valid), 1);
    chk("t31_y", int'(y), 10);
    @(negedge clk);
    chk("t31_done", int'(done_cnt), 1);
    // back-to-back, carry and max
    #1 got.delete();
    for (int i = 0; i < 4; i++) begin
      a = W'(i == 0 ? 3 : i == 1 ? 1 : i == 2 ? 12 : 15);
      b = W'(i == 0 ? 6 : i == 1 ? 4 : i == 2 ? 9 : 15);
      in_valid = 1;
      @(negedge clk);
      #1;
    end
    in_valid = 0;
    repeat (8) @(negedge clk);
    chk("t32_n", got.size(), 4);
    if (got.size() == 4) begin
      chk("t32_y0", got[0], 9);
      chk("t32_y1", got[1], 5);
      chk("t32_y2", got[2], 21);
      chk("t32_msb", (got[2] >> 4) & 1, 1);
      chk("t32_y3", got[3], 30);
    end
    // fill with consumer stalled
    #1 out_ready = 0; acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      a = W'(i + 1); b = W'(i + 2); in_valid = 1;
      @(negedge clk);
      #1;
    end
    chk("t33_acc", acc_cnt, 4);
    chk("t33_ready", int'(in_ready), 0);
    chk("t33_state", int'(state), 2);
    repeat (3) @(negedge clk);
    chk("t33_y_hold", int'(y), 3);
    // full with both sides streaming
    #1 out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      a = W'(i % 16); b = W'(15 - (i * 3) % 16);
      @(negedge clk);
      #1;
    end
    in_valid = 0;
    repeat (8) @(negedge clk);
    chk("t34_drained", int'(state), 0);
    // async reset with 3 buffered
    #1 out_ready = 0; in_valid = 1; a = 7; b = 8;
    repeat (3) @(negedge clk);
    #1 in_valid = 0;
    repeat (2) @(negedge clk);
    chk("t35_pre_ov", int'(out_valid), 1);
    #3 rst = 1;
    #1;
    chk("t35_ov", int'(out_valid), 0);
    chk("t35_done", int'(done_cnt), 0);
    chk("t35_state", int'(state), 0);
    chk("t35_ready", int'(in_ready), 0);
    @(negedge clk);
    #1 rst = 0; out_ready = 1;
    repeat (3) @(negedge clk);
    chk("t35_no_stale_ov", int'(out_valid), 0);
    chk("t35_no_stale_y", int'(y), 0);
    // done_cnt wrap
    #1 acc_cnt = 0;
    for (int i = 0; i < 1200 && !(acc_cnt >= 256 && !pend && q.size() == 0); i++) begin
      in_valid = acc_cnt < 256;
      a = W'(i % 16); b = 3;
      @(negedge clk);
      #1;
    end
    in_valid = 0;
    chk("t36_acc", acc_cnt, 256);
    chk("t36_done256", int'(done_cnt), 0);
    in_valid = 1; a = 1; b = 1;
    @(negedge clk);
    #1 in_valid = 0;
    repeat (4) @(negedge clk);
    chk("t36_done257", int'(done_cnt), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
